cnn_result_argmax: RTL and testbench

Downstream consumer of the CNN core. It captures each 4-word FP32 result burst (out_valid/out of the CNN) and computes, on the fly, the index and value of the largest of the four words. Results are buffered in a small FIFO and presented on a valid/ready interface to the classification/host stage. Protocol errors are flagged with sticky bits.

---
 rtl/cnn_result_argmax.sv | 148 ++++++++++++++
 tb/tb_cnn_result_argmax.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/cnn_result_argmax.sv
// Captures 4-word FP32 result bursts, tracks the largest word on the fly and
// queues {index, value} results in a small FIFO behind a valid/ready interface.
module cnn_result_argmax #(
  parameter int FIFO_DEPTH = 2,
  parameter int DATA_W     = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [1:0]        out_idx,
  output logic [DATA_W-1:0] out_max,
  output logic              err_trunc,
  output logic              err_ovf,
  input  logic              clr_err
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  // Monotonic key: negatives map below +0, positives above; both zeros collapse.
  function automatic logic [DATA_W-1:0] cmp_key(input logic [DATA_W-1:0] b);
    if (b[DATA_W-2:0] == '0)
      return {1'b1, {(DATA_W-1){1'b0}}};
    else if (!b[DATA_W-1])
      return {1'b1, b[DATA_W-2:0]};
    else
      return ~b;
  endfunction

  logic [1:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] max_key_q, max_key_d;
  logic [DATA_W-1:0] max_bits_q, max_bits_d;
  logic [1:0]        max_idx_q, max_idx_d;

  logic [DATA_W-1:0] mem_bits_q [FIFO_DEPTH];
  logic [1:0]        mem_idx_q  [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;

  logic              out_valid_q, out_valid_d;
  logic [1:0]        out_idx_q, out_idx_d;
  logic [DATA_W-1:0] out_max_q, out_max_d;
  logic              err_trunc_q, err_trunc_d;
  logic              err_ovf_q, err_ovf_d;

  logic [DATA_W-1:0] word_key;
  logic              take_word;
  logic              push, pop, full, push_ok, ovf_evt, trunc_evt;
  logic [DATA_W-1:0] head_bits;
  logic [1:0]        head_idx;

  always_comb begin
    word_key   = cmp_key(in_data);
    take_word  = (cnt_q == 2'd0) || (word_key > max_key_q);
    max_key_d  = max_key_q;
    max_bits_d = max_bits_q;
    max_idx_d  = max_idx_q;
    cnt_d      = 2'd0;
    if (in_valid) begin
      cnt_d = cnt_q + 2'd1;
      if (take_word) begin
        max_key_d  = word_key;
        max_bits_d = in_data;
        max_idx_d  = cnt_q;
      end
    end

    push      = in_valid && (cnt_q == 2'd3);
    pop       = out_valid_q && out_ready;
    full      = (count_q == DEPTH_C);
    push_ok   = push && (!full || pop);
    ovf_evt   = push && full && !pop;
    trunc_evt = !in_valid && (cnt_q != 2'd0);

    wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop     ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push_ok && !pop)
      count_d = count_q + CW'(1);
    else if (!push_ok && pop)
      count_d = count_q - CW'(1);

    // The new head may be the entry being written this very edge.
    if (push_ok && (rd_ptr_d == wr_ptr_q)) begin
      head_bits = max_bits_d;
      head_idx  = max_idx_d;
    end else begin
      head_bits = mem_bits_q[rd_ptr_d];
      head_idx  = mem_idx_q[rd_ptr_d];
    end

    out_valid_d = (count_d != '0);
    out_max_d   = out_valid_d ? head_bits : '0;
    out_idx_d   = out_valid_d ? head_idx  : 2'd0;

    err_trunc_d = (err_trunc_q && !clr_err) || trunc_evt;
    err_ovf_d   = (err_ovf_q   && !clr_err) || ovf_evt;
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_bits_q[wr_ptr_q] <= max_bits_d;
      mem_idx_q[wr_ptr_q]  <= max_idx_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= 2'd0;
      max_key_q   <= '0;
      max_bits_q  <= '0;
      max_idx_q   <= 2'd0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_idx_q   <= 2'd0;
      out_max_q   <= '0;
      err_trunc_q <= 1'b0;
      err_ovf_q   <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      max_key_q   <= max_key_d;
      max_bits_q  <= max_bits_d;
      max_idx_q   <= max_idx_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
      out_max_q   <= out_max_d;
      err_trunc_q <= err_trunc_d;
      err_ovf_q   <= err_ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;
  assign out_max   = out_max_q;
  assign err_trunc = err_trunc_q;
  assign err_ovf   = err_ovf_q;

endmodule

// File: tb/tb_cnn_result_argmax.sv
// Directed bench for cnn_result_argmax: argmax ordering, FIFO back-pressure,
// overflow, truncation, sticky-flag clearing and asynchronous reset.
module tb_cnn_result_argmax;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_data;
  logic        out_ready;
  logic        out_valid;
  logic [1:0]  out_idx;
  logic [31:0] out_max;
  logic        err_trunc;
  logic        err_ovf;
  logic        clr_err;

  int checks   = 0;
  int failures = 0;

  cnn_result_argmax #(.FIFO_DEPTH(2), .DATA_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_idx   (out_idx),
    .out_max   (out_max),
    .err_trunc (err_trunc),
    .err_ovf   (err_ovf),
    .clr_err   (clr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [1:0] idx, input logic [31:0] mx);
    chk({tag, ".valid"}, {31'd0, out_valid}, {31'd0, v});
    chk({tag, ".idx"},   {30'd0, out_idx},   {30'd0, idx});
    chk({tag, ".max"},   out_max,            mx);
    $display("step %s: valid=%0b idx=%0d max=%h trunc=%0b ovf=%0b",
             tag, out_valid, out_idx, out_max, err_trunc, err_ovf);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic word(input logic [31:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_data  = 32'h0;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = 32'h0; out_ready = 1'b0; clr_err = 1'b0;
    tick(); tick();
    chk_out("reset", 1'b0, 2'd0, 32'h0);
    chk("reset.trunc", {31'd0, err_trunc}, 32'd0);
    chk("reset.ovf",   {31'd0, err_ovf},   32'd0);
    #3 rst_n = 1'b1;
    tick();

    // Basic burst, result visible at the edge that samples word 3.
    out_ready = 1'b1;
    word(32'h3F800000); word(32'hC0000000); word(32'h40400000);
    chk_out("basic.w2", 1'b0, 2'd0, 32'h0);
    word(32'h3F000000);
    chk_out("basic.w3", 1'b1, 2'd2, 32'h40400000);
    idle();
    chk_out("basic.after", 1'b0, 2'd0, 32'h0);
    chk("basic.trunc", {31'd0, err_trunc}, 32'd0);

    // All-negative burst followed back-to-back by signed-zero tie burst.
    word(32'hBF800000); word(32'hC0000000); word(32'hBF000000); word(32'hC0400000);
    chk_out("neg", 1'b1, 2'd2, 32'hBF000000);
    word(32'h80000000);
    chk_out("neg.pop", 1'b0, 2'd0, 32'h0);
    word(32'h00000000); word(32'hBF800000); word(32'hC0000000);
    chk_out("zero_tie", 1'b1, 2'd0, 32'h80000000);
    idle();
    chk_out("zero_tie.after", 1'b0, 2'd0, 32'h0);
    chk("b2b.trunc", {31'd0, err_trunc}, 32'd0);

    // Back-pressure with overflow: third burst dropped.
    out_ready = 1'b0;
    word(32'h3F800000); word(32'h0); word(32'h0); word(32'h0);
    chk_out("bp.first", 1'b1, 2'd0, 32'h3F800000);
    word(32'h0); word(32'h40000000); word(32'h3F800000); word(32'h0);
    chk_out("bp.second_held", 1'b1, 2'd0, 32'h3F800000);
    chk("bp.no_ovf_yet", {31'd0, err_ovf}, 32'd0);
    word(32'h0); word(32'h0); word(32'h0); word(32'h40400000);
    chk("bp.ovf", {31'd0, err_ovf}, 32'd1);
    chk_out("bp.hold", 1'b1, 2'd0, 32'h3F800000);
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk_out("bp.pop1", 1'b1, 2'd1, 32'h40000000);
    tick();
    chk_out("bp.pop2", 1'b0, 2'd0, 32'h0);
    chk("bp.ovf_sticky", {31'd0, err_ovf}, 32'd1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("bp.ovf_clr", {31'd0, err_ovf}, 32'd0);

    // Full FIFO with pop in the same cycle as the push.
    out_ready = 1'b0;
    word(32'h3F800000); word(32'h0); word(32'h0); word(32'h0);
    word(32'h0); word(32'h40000000); word(32'h3F800000); word(32'h0);
    word(32'h0); word(32'h0); word(32'h0);
    out_ready = 1'b1;
    word(32'h40400000);
    chk("pp.no_ovf", {31'd0, err_ovf}, 32'd0);
    chk_out("pp.head2", 1'b1, 2'd1, 32'h40000000);
    idle();
    chk_out("pp.head3", 1'b1, 2'd3, 32'h40400000);
    idle();
    chk_out("pp.empty", 1'b0, 2'd0, 32'h0);
    chk("pp.no_ovf_end", {31'd0, err_ovf}, 32'd0);

    // Truncation then recovery.
    word(32'h40000000); word(32'h40400000);
    idle();
    chk("trunc.flag", {31'd0, err_trunc}, 32'd1);
    chk_out("trunc.no_result", 1'b0, 2'd0, 32'h0);
    word(32'h3F800000); word(32'hC0000000); word(32'h40400000); word(32'h3F000000);
    chk_out("trunc.recover", 1'b1, 2'd2, 32'h40400000);
    idle();
    // Clear coinciding with a new truncation: flag stays set.
    word(32'h3F800000);
    in_valid = 1'b0; clr_err = 1'b1;
    tick();
    chk("trunc.clr_vs_evt", {31'd0, err_trunc}, 32'd1);
    tick();
    clr_err = 1'b0;
    chk("trunc.clr", {31'd0, err_trunc}, 32'd0);

    // Asynchronous reset mid-burst with a buffered result.
    out_ready = 1'b0;
    word(32'h3F800000); word(32'h0); word(32'h0); word(32'h0);
    word(32'h40000000); word(32'h40400000);
    chk_out("rst.pre", 1'b1, 2'd0, 32'h3F800000);
    #2 rst_n = 1'b0;
    #1;
    chk_out("rst.async", 1'b0, 2'd0, 32'h0);
    in_valid = 1'b0;
    tick();
    #3 rst_n = 1'b1;
    tick();
    out_ready = 1'b1;
    word(32'hBF800000); word(32'hC0000000); word(32'hBF000000);
    chk_out("rst.w2", 1'b0, 2'd0, 32'h0);
    word(32'hC0400000);
    chk_out("rst.recount", 1'b1, 2'd2, 32'hBF000000);
    chk("rst.trunc", {31'd0, err_trunc}, 32'd0);
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
